// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: mode constants and select-width helper for stream_mux_rr
package stream_mux_pkg;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;
  function automatic int sel_width(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant (req, ptr -> one-hot grant, gidx, any) via rotate/encode/rotate-back
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int NCH = 8,
  localparam int SELW = sel_width(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic [NCH-1:0]  grant,
  output logic [SELW-1:0] gidx,
  output logic            any
);
  logic [NCH-1:0]  rot;
  logic [SELW-1:0] ridx;
  always_comb begin
    rot  = '0;
    ridx = '0;
    for (int i = 0; i < NCH; i++) rot[i] = req[(i + int'(ptr)) % NCH];
    for (int i = NCH - 1; i >= 0; i--) if (rot[i]) ridx = SELW'(i);
    any   = |rot;
    gidx  = SELW'((int'(ridx) + int'(ptr)) % NCH);
    grant = any ? {{(NCH-1){1'b0}}, 1'b1} << gidx : '0;
  end
endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: registered NCH:1 valid/ready stream mux; mode/sel pick fixed or round-robin source, out_data/out_ch/out_valid registered
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 8,
  localparam int SELW = sel_width(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]       in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch
);
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_ch_q, out_ch_d, ptr_q, ptr_d, rr_idx, gidx;
  logic [NCH-1:0]   rr_grant, fx_grant, grant;
  logic             rr_any, fx_hit, load, xfer;
  rr_arbiter #(.NCH(NCH)) u_arb (
    .req  (in_valid),
    .ptr  (ptr_q),
    .grant(rr_grant),
    .gidx (rr_idx),
    .any  (rr_any)
  );
  always_comb begin
    fx_hit      = (int'(sel) < NCH) && in_valid[sel];
    fx_grant    = fx_hit ? {{(NCH-1){1'b0}}, 1'b1} << sel : '0;
    grant       = (mode == MODE_RR) ? rr_grant : fx_grant;
    gidx        = (mode == MODE_RR) ? rr_idx : sel;
    load        = !out_valid_q || out_ready;
    xfer        = load && !rst && ((mode == MODE_RR) ? rr_any : fx_hit);
    in_ready    = xfer ? grant : '0;
    out_valid_d = xfer || (out_valid_q && !out_ready);
    out_data_d  = xfer ? in_data[gidx*WIDTH +: WIDTH] : out_data_q;
    out_ch_d    = xfer ? gidx : out_ch_q;
    ptr_d       = (xfer && mode == MODE_RR) ? ((int'(gidx) == NCH - 1) ? '0 : gidx + 1'b1) : ptr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: randomized and directed checks of stream_mux_rr against a behavioural model
module tb_stream_mux_rr;
  localparam int N = 8;
  logic clk = 1'b0;
  logic rst, mode, out_ready, out_valid;
  logic [2:0] sel, out_ch;
  logic [N-1:0] in_valid, in_ready;
  logic [N*8-1:0] in_data;
  logic [7:0] out_data;
  logic mode5, out_ready5, out_valid5;
  logic [2:0] sel5, out_ch5;
  logic [4:0] in_valid5, in_ready5;
  logic [39:0] in_data5;
  logic [7:0] out_data5;
  int n_cmp = 0, n_err = 0;
  logic m_v;
  logic [7:0] m_d;
  int m_c, m_ptr;
  always #5 clk = ~clk;
  stream_mux_rr #(.WIDTH(8), .NCH(8)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch)
  );
  stream_mux_rr #(.WIDTH(8), .NCH(5)) dut5 (
    .clk(clk), .rst(rst), .mode(mode5), .sel(sel5), .in_valid(in_valid5), .in_data(in_data5),
    .in_ready(in_ready5), .out_valid(out_valid5), .out_ready(out_ready5), .out_data(out_data5), .out_ch(out_ch5)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // Settle inputs, check ready against the model's grant, clock once, check the registered outputs.
  task automatic cycle();
    int g;
    logic [N-1:0] er;
    #1;
    g = -1;
    if (mode == 1'b0) begin
      if (int'(sel) < N && in_valid[sel]) g = int'(sel);
    end else begin
      for (int k = 0; k < N && g < 0; k++)
        if (in_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    end
    er = (!rst && (!m_v || out_ready) && g >= 0) ? N'(1) << g : '0;
    chk("in_ready", in_ready, er);
    if (rst) begin
      m_v = 0; m_d = 0; m_c = 0; m_ptr = 0;
    end else if (er != 0) begin
      m_v = 1; m_d = in_data[g*8 +: 8]; m_c = g;
      if (mode) m_ptr = (g + 1) % N;
    end else if (out_ready) m_v = 0;
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, m_v);
    chk("out_data", out_data, m_d);
    chk("out_ch", out_ch, m_c);
  endtask
  initial begin
    int rr_exp [6] = '{0, 3, 7, 0, 3, 7};
    m_v = 0; m_d = 0; m_c = 0; m_ptr = 0;
    rst = 1; mode = 1; sel = 0; in_valid = '1; out_ready = 1; in_data = {$urandom, $urandom};
    mode5 = 0; sel5 = 0; in_valid5 = '0; out_ready5 = 1; in_data5 = 40'h44_33_22_11_00;
    cycle();
    cycle();
    chk("rst_ready5", in_ready5, 0);
    chk("rst_ov5", out_valid5, 0);
    rst = 0;
    cycle();
    chk("post_rst_ch", out_ch, 0);
    chk("post_rst_ov", out_valid, 1);
    // NCH=5: out-of-range sel gives no grant; switching to RR resumes at ptr 0
    mode5 = 0; sel5 = 3'd6; in_valid5 = 5'h1F;
    #1 chk("n5_sel6_ready", in_ready5, 0);
    @(posedge clk); #1 chk("n5_sel6_ov", out_valid5, 0);
    mode5 = 1; in_valid5 = 5'b10100;
    #1 chk("n5_rr_ready0", in_ready5, 5'b00100);
    @(posedge clk); #1 chk("n5_rr_ch0", out_ch5, 2);
    chk("n5_rr_ov", out_valid5, 1);
    #1 chk("n5_rr_ready1", in_ready5, 5'b10000);
    @(posedge clk); #1 chk("n5_rr_ch1", out_ch5, 4);
    in_valid5 = '0;
    // Resync the model since the DUT8 ran idle-free cycles above
    rst = 1; cycle(); rst = 0;
    mode = 0; sel = 5; in_valid = '1; in_data = {$urandom, $urandom}; in_data[5*8 +: 8] = 8'hA5;
    #1 chk("fixed_ready", in_ready, 8'h20);
    cycle();
    chk("fixed_data", out_data, 8'hA5);
    chk("fixed_ch", out_ch, 5);
    rst = 1; cycle(); rst = 0;
    mode = 1; in_valid = 8'b1000_1001;
    for (int i = 0; i < 6; i++) begin
      in_data = {$urandom, $urandom};
      cycle();
      chk("rr_seq", out_ch, rr_exp[i]);
    end
    out_ready = 0; in_valid = '1;
    for (int i = 0; i < 3; i++) begin
      in_data = {$urandom, $urandom};
      cycle();
      chk("stall_ch", out_ch, 7);
    end
    out_ready = 1;
    #1 chk("unstall_ready", in_ready, 8'h01);
    cycle();
    out_ready = 0;
    cycle();
    rst = 1;
    cycle();
    chk("rst_mid_ov", out_valid, 0);
    rst = 0; in_valid = '0;
    cycle();
    chk("rst_mid_hold", out_valid, 0);
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 60) == 0);
      mode = $urandom_range(0, 1);
      sel = 3'($urandom);
      in_valid = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom & $urandom);
      in_data = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
